// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared instruction/data memory port: data-first priority with a
// streak limit that forces fetch through, request/ack sequencing and ack timeout.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT         = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wd,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_f,
  output logic        stall_m,
  output logic        owner,
  output logic        busy,
  output logic        err
);

  localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wd_q, mem_wd_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          if_done_q, if_done_d;
  logic          dm_done_q, dm_done_d;
  logic          owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic fetch_elig, data_elig, expire;

  // A requester's req is still high during its done cycle; mask it there.
  assign fetch_elig = if_req & ~if_done_q;
  assign data_elig  = dm_req & ~dm_done_q;
  assign expire     = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    owner_d    = owner_q;
    busy_d     = busy_q;
    err_d      = err_q;
    streak_d   = streak_q;
    tmo_d      = tmo_q;

    unique case (state_q)
      S_IDLE: begin
        if (data_elig && !(fetch_elig && streak_q == STREAK_MAX)) begin
          state_d    = S_BUSY;
          mem_req_d  = 1'b1;
          busy_d     = 1'b1;
          owner_d    = 1'b1;
          mem_we_d   = dm_we;
          mem_addr_d = dm_addr;
          mem_wd_d   = dm_wd;
          tmo_d      = '0;
          // Fetch eligible here implies streak_q < STREAK_MAX, so no overflow.
          streak_d   = fetch_elig ? streak_q + SW'(1) : '0;
        end else if (fetch_elig) begin
          state_d    = S_BUSY;
          mem_req_d  = 1'b1;
          busy_d     = 1'b1;
          owner_d    = 1'b0;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          mem_wd_d   = '0;
          tmo_d      = '0;
          streak_d   = '0;
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          if (owner_q) begin
            dm_done_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = mem_rdata;
          end else begin
            if_done_d = 1'b1;
            if (!mem_we_q) if_rdata_d = mem_rdata;
          end
        end else if (expire) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
          tmo_d     = tmo_q + TW'(1);
          if (owner_q) begin
            dm_done_d  = 1'b1;
            dm_rdata_d = '0;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = '0;
          end
        end else if (TIMEOUT != 0) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      owner_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      streak_q   <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      streak_q   <= streak_d;
      tmo_q      <= tmo_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign if_done  = if_done_q;
  assign dm_done  = dm_done_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign stall_f  = if_req & ~if_done_q;
  assign stall_m  = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: random fetch/data masters and a random-latency
// memory, checked every cycle against a transaction-level reference of the port.
module tb_mem_port_arbiter;

  localparam int unsigned MAXS  = 4;
  localparam int unsigned TMO   = 8;
  localparam int unsigned NEVER = 1000;
  localparam int unsigned NCYC  = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_done, dm_req, dm_we, dm_done;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wd, dm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wd, mem_rdata;
  logic        stall_f, stall_m, owner, busy, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DATA_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_f(stall_f), .stall_m(stall_m), .owner(owner), .busy(busy), .err(err)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the port either holds one transaction or is free.
  typedef struct {
    bit          own_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    int unsigned waited;
    int unsigned ack_at;
  } txn_t;

  txn_t        cur;
  bit          port_busy, e_if_done, e_dm_done, e_err;
  logic [31:0] e_if_rdata, e_dm_rdata;
  int unsigned streak;

  function automatic int unsigned pick_latency();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 5) return $urandom_range(0, 3);
    if (r == 6) return TMO - 1;
    if (r == 7) return TMO - 2;
    if (r == 8) return NEVER;
    return 0;
  endfunction

  task automatic model_reset();
    port_busy  = 1'b0;
    e_if_done  = 1'b0;
    e_dm_done  = 1'b0;
    e_err      = 1'b0;
    e_if_rdata = '0;
    e_dm_rdata = '0;
    streak     = 0;
    cur        = '{0, 0, '0, '0, 0, 0};
  endtask

  task automatic start_txn(input bit d, input bit w, input logic [31:0] a, input logic [31:0] wd);
    port_busy = 1'b1;
    cur = '{d, w, a, wd, 0, pick_latency()};
  endtask

  initial begin
    bit          fe, de, timed_out;
    int unsigned p_req, p_drop;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wd = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();

    @(negedge clk);
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_wd", mem_wd, 0);
    check("reset_owner", owner, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_if_rdata", if_rdata, 0);
    check("reset_dm_rdata", dm_rdata, 0);
    rst = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      check("mem_req", mem_req, port_busy);
      check("busy", busy, port_busy);
      check("if_done", if_done, e_if_done);
      check("dm_done", dm_done, e_dm_done);
      check("if_rdata", if_rdata, e_if_rdata);
      check("dm_rdata", dm_rdata, e_dm_rdata);
      check("err", err, e_err);
      if (port_busy) begin
        check("owner", owner, cur.own_data);
        check("mem_we", mem_we, cur.we);
        check("mem_addr", mem_addr, cur.addr);
        check("mem_wd", mem_wd, cur.wd);
      end

      // Asynchronous reset between edges, mid-run.
      if (cyc == 700 || cyc == 1500 || cyc == 2200) begin
        #2 rst = 1'b1;
        #1;
        check("async_rst_mem_req", mem_req, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_err", err, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end

      // Persistent-request window exercises the data streak limit.
      if (cyc >= 1200 && cyc < 1800) begin p_req = 100; p_drop = 0; end
      else begin p_req = 40; p_drop = 50; end

      if (!if_req) begin
        if ($urandom_range(0, 99) < p_req) begin
          if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
        end
      end else if (e_if_done) begin
        if ($urandom_range(0, 99) < p_drop) if_req = 1'b0;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end

      if (!dm_req) begin
        if ($urandom_range(0, 99) < p_req) begin
          dm_req = 1'b1; dm_we = $urandom_range(0, 1) == 1;
          dm_addr = $urandom & 32'hFFFF_FFFC; dm_wd = $urandom;
        end
      end else if (e_dm_done) begin
        if ($urandom_range(0, 99) < p_drop) dm_req = 1'b0;
        dm_we = $urandom_range(0, 1) == 1;
        dm_addr = $urandom & 32'hFFFF_FFFC; dm_wd = $urandom;
      end

      mem_rdata = $urandom;
      if (port_busy) mem_ack = (cur.waited == cur.ack_at);
      else           mem_ack = ($urandom_range(0, 9) == 0);

      #1;
      check("stall_f", stall_f, if_req & ~e_if_done);
      check("stall_m", stall_m, dm_req & ~e_dm_done);

      fe = if_req && !e_if_done;
      de = dm_req && !e_dm_done;
      e_if_done = 1'b0;
      e_dm_done = 1'b0;
      if (!port_busy) begin
        if (de && !(fe && streak == MAXS)) begin
          start_txn(1'b1, dm_we, dm_addr, dm_wd);
          streak = fe ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
        end else if (fe) begin
          start_txn(1'b0, 1'b0, if_addr, 32'h0);
          streak = 0;
        end
      end else if (mem_ack || cur.waited + 1 == TMO) begin
        timed_out = !mem_ack;
        port_busy = 1'b0;
        if (timed_out) e_err = 1'b1;
        if (cur.own_data) begin
          e_dm_done = 1'b1;
          if (timed_out) e_dm_rdata = '0;
          else if (!cur.we) e_dm_rdata = mem_rdata;
        end else begin
          e_if_done = 1'b1;
          if (timed_out) e_if_rdata = '0;
          else e_if_rdata = mem_rdata;
        end
      end else begin
        cur.waited++;
      end

      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
